// File: rtl/car_sim_pkg.sv
// Shared widths, default parameters and FSM encoding for the car-sim sensor path.
package car_sim_pkg;

    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned LEVEL_W  = 4;

    localparam int unsigned DEF_SAMPLE_DIV     = 50000;
    localparam int unsigned DEF_AVG_LOG2       = 3;
    localparam int unsigned DEF_ACCEL_DEADZONE = 16;
    localparam int unsigned DEF_DARK_ON        = 60;
    localparam int unsigned DEF_DARK_OFF       = 80;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_UPDATE  = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    // Upper nibble of the average, forced to zero inside the pedal dead zone.
    function automatic logic [LEVEL_W-1:0] quantise(input logic [SAMPLE_W-1:0] avg,
                                                    input logic [SAMPLE_W-1:0] deadzone);
        return (avg < deadzone) ? '0 : avg[SAMPLE_W-1 -: LEVEL_W];
    endfunction

endpackage

// File: rtl/adc_conditioner_if.sv
// Raw ADC samples in, conditioned pedal/light values out.
interface adc_conditioner_if;
    import car_sim_pkg::*;

    logic [SAMPLE_W-1:0] adc_accel;
    logic [SAMPLE_W-1:0] adc_cds;
    logic [SAMPLE_W-1:0] accel_avg;
    logic [SAMPLE_W-1:0] cds_avg;
    logic [LEVEL_W-1:0]  throttle_level;
    logic                dark;
    logic                out_valid;

    modport master (
        output adc_accel, adc_cds,
        input  accel_avg, cds_avg, throttle_level, dark, out_valid
    );

    modport slave (
        input  adc_accel, adc_cds,
        output accel_avg, cds_avg, throttle_level, dark, out_valid
    );

endinterface

// File: rtl/adc_conditioner_moving_avg.sv
// Boxcar filter state for one channel: circular sample buffer plus running sum.
module moving_avg
    import car_sim_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en_i,
    input  logic [SAMPLE_W-1:0]          sample_i,
    output logic [SAMPLE_W+AVG_LOG2-1:0] sum_o
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SW    = SAMPLE_W + AVG_LOG2;

    logic [SAMPLE_W-1:0] buf_q [DEPTH];
    logic [AVG_LOG2-1:0] ptr_q;
    logic [SW-1:0]       sum_q;
    logic [SW-1:0]       sum_d;

    // Modular arithmetic: the true result is non-negative, so a transient borrow cancels.
    always_comb sum_d = sum_q + SW'(sample_i) - SW'(buf_q[ptr_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) buf_q[i] <= '0;
            ptr_q <= '0;
            sum_q <= '0;
        end else if (en_i) begin
            buf_q[ptr_q] <= sample_i;
            ptr_q        <= ptr_q + AVG_LOG2'(1);
            sum_q        <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/adc_conditioner.sv
// Samples both ADC channels at a fixed rate, averages them, and derives
// a throttle level and a hysteretic headlight request.
module adc_conditioner
    import car_sim_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV     = DEF_SAMPLE_DIV,
    parameter int unsigned AVG_LOG2       = DEF_AVG_LOG2,
    parameter int unsigned ACCEL_DEADZONE = DEF_ACCEL_DEADZONE,
    parameter int unsigned DARK_ON        = DEF_DARK_ON,
    parameter int unsigned DARK_OFF       = DEF_DARK_OFF
) (
    input logic               clk,
    input logic               rst_n,
    adc_conditioner_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned CW    = $clog2(SAMPLE_DIV);
    localparam int unsigned FW    = AVG_LOG2 + 1;
    localparam int unsigned SW    = SAMPLE_W + AVG_LOG2;

    logic [CW-1:0]       div_q;
    logic [CW-1:0]       div_d;
    logic                tick_c;
    state_t              state_q;
    logic [FW-1:0]       fill_q;
    logic [SAMPLE_W-1:0] accel_cap_q;
    logic [SAMPLE_W-1:0] cds_cap_q;
    logic [SW-1:0]       accel_sum;
    logic [SW-1:0]       cds_sum;
    logic [SAMPLE_W-1:0] accel_avg_c;
    logic [SAMPLE_W-1:0] cds_avg_c;
    logic                update_c;
    logic [SAMPLE_W-1:0] accel_avg_q;
    logic [SAMPLE_W-1:0] cds_avg_q;
    logic [LEVEL_W-1:0]  throttle_q;
    logic                dark_q;
    logic                out_valid_q;

    // Sample-rate divider
    always_comb begin
        tick_c = (div_q == CW'(SAMPLE_DIV - 1));
        div_d  = tick_c ? '0 : div_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_q <= '0;
        else        div_q <= div_d;
    end

    assign update_c    = (state_q == S_UPDATE);
    assign accel_avg_c = SAMPLE_W'(accel_sum >> AVG_LOG2);
    assign cds_avg_c   = SAMPLE_W'(cds_sum >> AVG_LOG2);

    moving_avg #(.AVG_LOG2(AVG_LOG2)) u_accel_avg (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (update_c),
        .sample_i (accel_cap_q),
        .sum_o    (accel_sum)
    );

    moving_avg #(.AVG_LOG2(AVG_LOG2)) u_cds_avg (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (update_c),
        .sample_i (cds_cap_q),
        .sum_o    (cds_sum)
    );

    // Capture -> filter update -> publish; outputs stay frozen until the buffer has filled once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fill_q      <= '0;
            accel_cap_q <= '0;
            cds_cap_q   <= '0;
            accel_avg_q <= '0;
            cds_avg_q   <= '0;
            throttle_q  <= '0;
            dark_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (tick_c) state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    accel_cap_q <= bus.adc_accel;
                    cds_cap_q   <= bus.adc_cds;
                    if (fill_q != FW'(DEPTH)) fill_q <= fill_q + FW'(1);
                    state_q <= S_UPDATE;
                end
                S_UPDATE: begin
                    state_q <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (fill_q == FW'(DEPTH)) begin
                        accel_avg_q <= accel_avg_c;
                        cds_avg_q   <= cds_avg_c;
                        throttle_q  <= quantise(accel_avg_c, SAMPLE_W'(ACCEL_DEADZONE));
                        if (cds_avg_c < SAMPLE_W'(DARK_ON))       dark_q <= 1'b1;
                        else if (cds_avg_c > SAMPLE_W'(DARK_OFF)) dark_q <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.accel_avg      = accel_avg_q;
    assign bus.cds_avg        = cds_avg_q;
    assign bus.throttle_level = throttle_q;
    assign bus.dark           = dark_q;
    assign bus.out_valid      = out_valid_q;

endmodule

// File: tb/tb_adc_conditioner.sv
// Directed-plus-random bench for adc_conditioner, scored against a sliding-window reference model.
module tb_adc_conditioner;

    localparam int SD   = 8;
    localparam int TAPS = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    adc_conditioner_if bus ();

    adc_conditioner #(.SAMPLE_DIV(SD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: last TAPS samples per channel plus the published values.
    int hist_a[$];
    int hist_c[$];
    int total    = 0;
    int exp_acc  = 0;
    int exp_cds  = 0;
    int exp_thr  = 0;
    int exp_dark = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int avg_of(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s / TAPS;
    endfunction

    task automatic model_reset();
        hist_a.delete();
        hist_c.delete();
        total    = 0;
        exp_acc  = 0;
        exp_cds  = 0;
        exp_thr  = 0;
        exp_dark = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_accel"}, bus.accel_avg, 8'(exp_acc));
        chk({tag, "_cds"}, bus.cds_avg, 8'(exp_cds));
        chk({tag, "_thr"}, 8'(bus.throttle_level), 8'(exp_thr));
        chk({tag, "_dark"}, 8'(bus.dark), 8'(exp_dark));
    endtask

    // One sample period: inputs presented at window start, out_valid expected on its last cycle.
    task automatic step(input int a, input int c, input bit glitch);
        bit vld;
        @(negedge clk);
        bus.adc_accel = 8'(a);
        bus.adc_cds   = 8'(c);
        chk("valid_low", 8'(bus.out_valid), 8'd0);
        for (int i = 1; i < SD; i++) begin
            @(negedge clk);
            if (glitch && (i == 1 || i == 5 || i == 6)) begin
                bus.adc_accel = 8'($urandom);
                bus.adc_cds   = 8'($urandom);
            end else if (glitch && i == 2) begin
                bus.adc_accel = 8'(a);
                bus.adc_cds   = 8'(c);
            end
            if (i == 3) begin
                chk("hold_accel", bus.accel_avg, 8'(exp_acc));
                chk("hold_dark", 8'(bus.dark), 8'(exp_dark));
            end
            if (i < SD - 1) chk("valid_low", 8'(bus.out_valid), 8'd0);
        end
        hist_a.push_back(a);
        hist_c.push_back(c);
        if (hist_a.size() > TAPS) begin
            void'(hist_a.pop_front());
            void'(hist_c.pop_front());
        end
        total++;
        vld = (total >= TAPS);
        if (vld) begin
            exp_acc = avg_of(hist_a);
            exp_cds = avg_of(hist_c);
            exp_thr = (exp_acc < 16) ? 0 : exp_acc / 16;
            if (exp_cds < 60)      exp_dark = 1;
            else if (exp_cds > 80) exp_dark = 0;
        end
        chk("valid_pulse", 8'(bus.out_valid), 8'(vld));
        chk_outputs("out");
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.adc_accel = 8'd0;
        bus.adc_cds   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs("reset");
        chk("reset_valid", 8'(bus.out_valid), 8'd0);
        release_reset();

        // Warm-up with constant 200/200
        for (int k = 0; k < TAPS; k++) step(200, 200, 1'b0);
        chk("warm_accel", bus.accel_avg, 8'd200);
        chk("warm_thr", 8'(bus.throttle_level), 8'd12);
        chk("warm_dark", 8'(bus.dark), 8'd0);

        for (int k = 0; k < 20; k++) step(int'($urandom_range(255)), int'($urandom_range(255)), 1'b0);

        // Pedal step 0 -> 255
        for (int k = 0; k < TAPS; k++) step(0, 120, 1'b0);
        for (int k = 0; k < 4; k++) step(255, 120, 1'b0);
        chk("step_half", bus.accel_avg, 8'd127);
        for (int k = 0; k < 4; k++) step(255, 120, 1'b0);
        chk("step_full", bus.accel_avg, 8'd255);
        chk("step_thr", 8'(bus.throttle_level), 8'd15);

        // Dead-zone edge
        for (int k = 0; k < TAPS; k++) step(15, 120, 1'b0);
        chk("dz_below", 8'(bus.throttle_level), 8'd0);
        for (int k = 0; k < TAPS; k++) step(16, 120, 1'b0);
        chk("dz_edge", 8'(bus.throttle_level), 8'd1);

        // Headlight hysteresis
        for (int k = 0; k < TAPS; k++) step(100, 70, 1'b0);
        chk("hyst_mid", 8'(bus.dark), 8'd0);
        for (int k = 0; k < TAPS; k++) step(100, 59, 1'b0);
        chk("hyst_on", 8'(bus.dark), 8'd1);
        for (int k = 0; k < TAPS; k++) step(100, 80, 1'b0);
        chk("hyst_hold", 8'(bus.dark), 8'd1);
        for (int k = 0; k < TAPS; k++) step(100, 81, 1'b0);
        chk("hyst_off", 8'(bus.dark), 8'd0);

        // Inputs wiggled outside the capture slot
        for (int k = 0; k < 12; k++) step(int'($urandom_range(255)), int'($urandom_range(255)), 1'b1);

        // Asynchronous reset mid-run, then full warm-up again
        for (int k = 0; k < 5; k++) step(int'($urandom_range(64, 255)), int'($urandom_range(0, 50)), 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_outputs("async_rst");
        chk("async_rst_valid", 8'(bus.out_valid), 8'd0);
        repeat (3) @(posedge clk);
        release_reset();
        for (int k = 0; k < TAPS + 6; k++) step(int'($urandom_range(255)), int'($urandom_range(255)), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
